pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer and a synchronous flush. Sits between any two stages of the RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the plain enable/flush stage register with full back-pressure support. Throughput is one transfer per cycle with no combinational path from out_ready to in_ready.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- FLUSH_VALUE, 0, value driven on out_data while no valid entry is held (WIDTH bits; a NOP encoding may be passed for IF/ID)
- CNT_W, 16, width of statistics counters (used only with PIPE_STAGE_STATS_EN)
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  discard every held entry and the current input this cycle
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  stage can accept; registered
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  head entry, or FLUSH_VALUE when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (stats build only)
- flush_cnt  out  CNT_W  valid entries discarded by flush (stats build only)

## Operation
- Storage: main register (drives out_data), skid register, and valid bits main_v and skid_v.
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), FULL (both set). No other encoding is reachable.
- in_ready = !skid_v; forced to 0 while rst=0. out_valid = main_v.
- Accept = in_valid && in_ready && !flush. Release = out_valid && out_ready.
- EMPTY: accept → ONE, main←in_data.
- ONE:
  - accept and release → ONE, main←in_data.
  - accept without release → FULL, skid←in_data.
  - release without accept → EMPTY.
- FULL: release → ONE, main←skid. in_in_ready is 0, so no accept occurs.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- flush=1 has priority over everything: next state EMPTY, the input is discarded even if in_valid=1, and out_data returns to FLUSH_VALUE. A release in the same cycle still counts as a completed transfer downstream.
- out_data is FLUSH_VALUE whenever main_v=0, so downstream sees a bubble value, not stale data.

## Timing
- Reset (rst=0 at a clock edge) sets EMPTY. Resulting outputs:
  - out_valid=0, out_data=FLUSH_VALUE, in_ready=1 once rst=1.
  - stall_cnt=0, flush_cnt=0.
- Latency: an accepted input appears on out_data/out_valid the cycle after the accepting edge (1 cycle).
- Throughput: 1 transfer/cycle sustained when out_ready is held at 1.
- out_ready falling: up to one further input is absorbed into skid; in_ready drops the following cycle.
- in_ready depends only on registers (no out_ready→in_ready combinational path). out_data/out_valid are register outputs.
- Reset mid-operation: all entries lost, no partial update. Reset has priority over flush.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt and flush_cnt are implemented.
  - stall_cnt +1 on each cycle with out_valid && !out_ready && !flush.
  - flush_cnt += main_v + skid_v on each flush cycle.
  - Both saturate at 2^CNT_W−1 and clear on reset.
- Not defined: both ports are tied to 0 and no counter logic is synthesised. Handshake behaviour is identical.

## Test plan
- Reset, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 one cycle later each, in_ready constantly 1.
- Hold out_ready=0 while sending 0xA,0xB,0xC → 0xA in main, 0xB in skid, in_ready=0 from the next cycle, 0xC held upstream. Raise out_ready → outputs 0xA,0xB,0xC in order, no loss.
- FULL with flush=1 and in_valid=1 (0xDD) → next cycle out_valid=0, out_data=FLUSH_VALUE, in_ready=1, 0xDD never appears. With stats enabled, flush_cnt=2.
- Hold rst=0 during FULL state → out_valid=0, out_data=FLUSH_VALUE, counters 0; in_ready=0 while rst=0, then 1.
- Stats build, CNT_W=4: 20 stall cycles → stall_cnt saturates at 15. Non-stats build: stall_cnt=0 throughout.
- Random in_valid/out_ready/flush for 10k cycles against a reference queue model → order preserved, occupancy ≤2, out_data=FLUSH_VALUE whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STATS_EN to implement the stall_cnt/flush_cnt statistics counters.
module pipe_stage_skid #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Bit 0 is main_v and bit 1 is skid_v, so valid flags come straight off the state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             accept_s;
    logic             release_s;

    assign in_ready  = in_ready_q & rst;
    assign out_valid = state_q[0];
    assign out_data  = main_q;
    assign accept_s  = in_valid & in_ready & ~flush;
    assign release_s = state_q[0] & out_ready;

    // Handshake state machine; main_q reloads FLUSH_VALUE whenever it becomes empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= FLUSH_VALUE;
            skid_q     <= {WIDTH{1'b0}};
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state_q    <= EMPTY;
            main_q     <= FLUSH_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (accept_s && release_s) begin
                        main_q <= in_data;
                    end else if (accept_s) begin
                        state_q    <= FULL;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (release_s) begin
                        state_q <= EMPTY;
                        main_q  <= FLUSH_VALUE;
                    end
                end
                FULL: begin
                    if (release_s) begin
                        state_q    <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    main_q     <= FLUSH_VALUE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [1:0]       held_s;
    logic [CNT_W:0]   flush_sum_s;

    assign held_s      = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    assign flush_sum_s = {1'b0, flush_cnt_q} + {{(CNT_W-1){1'b0}}, held_s};
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    // Saturating statistics counters; a flush can discard two entries at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (state_q[0] && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                flush_cnt_q <= flush_sum_s[CNT_W] ? CNT_MAX : flush_sum_s[CNT_W-1:0];
            end
        end
    end
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, counter saturation
// sequence and randomized traffic against a FIFO-queue reference model.
module tb_pipe_stage_skid;
    localparam int            W    = 8;
    localparam int            CW   = 4;
    localparam int            CMAX = (1 << CW) - 1;
    localparam logic [W-1:0]  FV   = 8'hEE;
`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(W), .FLUSH_VALUE(FV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: an ordered queue of held entries (capacity two) plus counters.
    logic [W-1:0] mq[$];
    int           m_stall = 0;
    int           m_flush = 0;

    typedef struct {
        logic         r, f, iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         ev;
        logic [W-1:0] ed;
        logic         er;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit rel, acc;
        if (!rst) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else if (flush) begin
            m_flush = (m_flush + mq.size() > CMAX) ? CMAX : m_flush + mq.size();
            mq.delete();
        end else begin
            rel = (mq.size() > 0) && out_ready;
            acc = in_valid && (mq.size() < 2);
            if ((mq.size() > 0) && !out_ready && (m_stall < CMAX)) m_stall++;
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [W-1:0] ed;
        ed = (mq.size() > 0) ? mq[0] : FV;
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, ed});
        chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, rst && (mq.size() < 2)});
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, STATS ? m_stall : 32'd0);
        chk({tag, "_flush_cnt"}, {28'd0, flush_cnt}, STATS ? m_flush : 32'd0);
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic addv(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                        input logic ordy, input logic ev, input logic [W-1:0] ed, input logic er);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.er = er;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        //     r     f     iv    d      ordy  ev    ed     er
        addv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, FV,    1'b0);
        addv(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1);
        addv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, FV,    1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b1, 8'h0A, 1'b0);
        addv(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 8'h0A, 1'b0);
        addv(1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 8'h0B, 1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 8'h0C, 1'b1);
        addv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, FV,    1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0);
        addv(1'b1, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, FV,    1'b1);
        addv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, FV,    1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h03, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, FV,    1'b0);
        addv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, FV,    1'b0);
        addv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, FV,    1'b1);
        addv(1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 8'h06, 1'b1);
        addv(1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, FV,    1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].ed});
            chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].er});
            if (i == 13) begin
                chk("flush_full_cnt", {28'd0, flush_cnt}, STATS ? 32'd2 : 32'd0);
            end
            if (i == 18) begin
                chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
                chk("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
            end
        end

        // Twenty stall cycles saturate a 4-bit stall counter at 15.
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall_saturate", {28'd0, stall_cnt}, STATS ? 32'd15 : 32'd0);
        chk("stall_hold_data", {24'd0, out_data}, 32'h5A);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1) == 1, W'($urandom), ($urandom_range(0, 9) < 6));
            cmp_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
